instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised instruction-fetch stage that replaces the fixed PC register/PC+4 mux arrangement in the CPU top.
- Owns the fetch PC and issues reads to instruction memory under a busywait handshake.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO feeding the IF/ID boundary.
- Handles ID-stage hold (load-use stall) and EX-stage branch/jump redirect, including redirects that arrive while a memory access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_VECTOR, 32'h0000_0000, fetch PC after reset.
- INSTR_BYTES, 4, PC increment per fetched word.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- INSTR_MEM_ADDR  out  ADDR_WIDTH  address of current fetch request.
- INSTR_MEM_READ  out  1  fetch request valid.
- INSTR_MEM_BUSYWAIT  in  1  memory busy; response accepted in a cycle with READ=1 and BUSYWAIT=0.
- INSTRUCTION  in  DATA_WIDTH  read data; valid when the response is accepted.
- REDIRECT  in  1  branch/jump taken in EX (EX_BJ_SIG).
- REDIRECT_TARGET  in  ADDR_WIDTH  new fetch PC (EX ALU out).
- ID_HOLD  in  1  ID stage stalled; do not pop.
- ID_VALID  out  1  FIFO head valid.
- ID_PC  out  ADDR_WIDTH  PC of head instruction.
- ID_INSTRUCTION  out  DATA_WIDTH  head instruction.
- FIFO_LEVEL  out  $clog2(DEPTH+1)  current occupancy (debug/verification).

Behaviour:
- Reset (async, any cycle, including mid-access):
  - FETCH_PC=RESET_VECTOR, FIFO empty, state=FETCH, read/write pointers 0.
  - ID_VALID=0, FIFO_LEVEL=0, ID_PC=0, ID_INSTRUCTION=0.
  - Any in-flight memory word is dropped.
- State FETCH:
  - INSTR_MEM_READ = (FIFO_LEVEL < DEPTH); INSTR_MEM_ADDR = FETCH_PC.
  - Accept (READ & !BUSYWAIT & !REDIRECT): push {FETCH_PC, INSTRUCTION}; FETCH_PC += INSTR_BYTES (mod 2^ADDR_WIDTH).
  - While BUSYWAIT=1: READ and ADDR are held stable and FETCH_PC does not change.
- Pop: ID_VALID & !ID_HOLD & !REDIRECT advances the read pointer at the edge.
  - Push and pop in the same cycle leave the level unchanged.
  - READ is derived from the registered level, so a full FIFO does not fetch even if it pops that cycle.
- Head outputs:
  - ID_VALID = (FIFO_LEVEL != 0) & (state==FETCH).
  - ID_PC/ID_INSTRUCTION come combinationally from the head entry; they hold their last value when the FIFO is empty.
- REDIRECT in FETCH:
  - At the edge, FIFO is flushed (level=0), no push, no pop.
  - If no access is outstanding (READ=0, or READ=1 & BUSYWAIT=0): FETCH_PC=REDIRECT_TARGET, stay in FETCH, and the target is requested the next cycle.
  - If READ=1 & BUSYWAIT=1: latch the target into PENDING_PC and go to DRAIN.
- State DRAIN:
  - READ=1 and ADDR = the old FETCH_PC, held until BUSYWAIT=0.
  - That word is discarded (no push); FETCH_PC=PENDING_PC; next state FETCH.
  - ID_VALID=0 throughout.
  - A further REDIRECT during DRAIN overwrites PENDING_PC; the last target wins.
- Redirect latency: the target word is at the FIFO head, ID_VALID=1, two cycles after REDIRECT with a zero-wait memory.
- Fetch latency: a word accepted at edge N is visible at ID at edge N.
  - With zero-wait memory the first instruction after reset release appears after 1 cycle.
  - Sustained throughput is 1 instruction per cycle when ID_HOLD=0.
- REDIRECT with ID_HOLD both high: the redirect wins; the FIFO is flushed.
- Pointers wrap modulo DEPTH; FIFO_LEVEL saturates at neither end (overflow/underflow impossible by construction and asserted in simulation).

Test Plan:
- Reset, zero-wait memory returning word=addr, ID_HOLD=0 -> ID_PC 0,4,8,12... on consecutive cycles; ID_INSTRUCTION==ID_PC; READ never drops.
- ID_HOLD=1 for 8 cycles, DEPTH=4 -> FIFO_LEVEL reaches 4, READ=0, INSTR_MEM_ADDR frozen at 16. Release -> PCs 0,4,8,12,16 with no gap or duplicate.
- Memory with 3-cycle BUSYWAIT per access -> ADDR stable while busy; one push every 4 cycles; ID_PC sequence 0,4,8 in order.
- REDIRECT to 0x100 in a zero-wait cycle with 3 entries buffered -> FIFO_LEVEL=0 next cycle; next ID_PC=0x100, then 0x104.
- REDIRECT to 0x200 while BUSYWAIT=1 on address 0x20 -> DRAIN state; ADDR stays 0x20 until busywait clears; word from 0x20 never appears at ID; next ID_PC=0x200.
- RESET asserted mid-access with FIFO holding 2 entries -> outputs clear immediately (async); after release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues busywait-handshaked reads,
// and buffers returned words in a small prefetch FIFO feeding the ID stage.
module instr_fetch_unit #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          INSTR_BYTES  = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    output logic [ADDR_WIDTH-1:0]        INSTR_MEM_ADDR,
    output logic                         INSTR_MEM_READ,
    input  logic                         INSTR_MEM_BUSYWAIT,
    input  logic [DATA_WIDTH-1:0]        INSTRUCTION,
    input  logic                         REDIRECT,
    input  logic [ADDR_WIDTH-1:0]        REDIRECT_TARGET,
    input  logic                         ID_HOLD,
    output logic                         ID_VALID,
    output logic [ADDR_WIDTH-1:0]        ID_PC,
    output logic [DATA_WIDTH-1:0]        ID_INSTRUCTION,
    output logic [$clog2(DEPTH+1)-1:0]   FIFO_LEVEL
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [0:0] {S_FETCH = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_pending_pc;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [ADDR_WIDTH-1:0] r_hold_pc;
    logic [DATA_WIDTH-1:0] r_hold_instr;
    logic [ADDR_WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];

    logic w_read;
    logic w_valid;
    logic w_accept;
    logic w_pop;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_FETCH;
        else       r_state <= w_state_next;
    end

    // Next-state logic: a redirect that hits an outstanding busy access must drain it first
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: if (REDIRECT && w_read && INSTR_MEM_BUSYWAIT) w_state_next = S_DRAIN;
            S_DRAIN: if (!INSTR_MEM_BUSYWAIT)                      w_state_next = S_FETCH;
            default: w_state_next = S_FETCH;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        w_read   = 1'b1;
        w_valid  = 1'b0;
        if (r_state == S_FETCH) begin
            w_read  = (r_level < LW'(DEPTH));
            w_valid = (r_level != '0);
        end
        w_accept = (r_state == S_FETCH) && w_read && !INSTR_MEM_BUSYWAIT && !REDIRECT;
        w_pop    = w_valid && !ID_HOLD && !REDIRECT;
    end

    assign INSTR_MEM_READ = w_read;
    assign INSTR_MEM_ADDR = r_fetch_pc;
    assign ID_VALID       = w_valid;
    assign FIFO_LEVEL     = r_level;
    // Empty FIFO shows the last head seen rather than a stale slot
    assign ID_PC          = (r_level != '0) ? r_mem_pc[r_rd_ptr]    : r_hold_pc;
    assign ID_INSTRUCTION = (r_level != '0) ? r_mem_instr[r_rd_ptr] : r_hold_instr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fetch_pc   <= RESET_VECTOR[ADDR_WIDTH-1:0];
            r_pending_pc <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else begin
            if (r_state == S_FETCH) begin
                if (REDIRECT) begin
                    if (w_read && INSTR_MEM_BUSYWAIT) r_pending_pc <= REDIRECT_TARGET;
                    else                              r_fetch_pc   <= REDIRECT_TARGET;
                end else if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
                end
            end else begin
                if (REDIRECT) r_pending_pc <= REDIRECT_TARGET;
                if (!INSTR_MEM_BUSYWAIT)
                    r_fetch_pc <= REDIRECT ? REDIRECT_TARGET : r_pending_pc;
            end

            if (r_level != '0) begin
                r_hold_pc    <= r_mem_pc[r_rd_ptr];
                r_hold_instr <= r_mem_instr[r_rd_ptr];
            end

            if (REDIRECT) begin
                r_level  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_accept, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= INSTRUCTION;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
        !(w_accept && !w_pop && r_level == LW'(DEPTH)));
    a_no_underflow: assert property (@(posedge CLK) disable iff (RESET)
        !(w_pop && !w_accept && r_level == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns word == address with a
// programmable busywait; expected values are hand-derived per scenario.
module tb_instr_fetch_unit;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTR_MEM_ADDR;
    logic        INSTR_MEM_READ;
    logic        INSTR_MEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_TARGET = '0;
    logic        ID_HOLD = 1'b0;
    logic        ID_VALID;
    logic [31:0] ID_PC;
    logic [31:0] ID_INSTRUCTION;
    logic [2:0]  FIFO_LEVEL;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mem_force_busy = 1'b0;
    int unsigned mem_wait = 0;
    int unsigned mem_cnt;

    instr_fetch_unit dut (
        .CLK(CLK), .RESET(RESET),
        .INSTR_MEM_ADDR(INSTR_MEM_ADDR), .INSTR_MEM_READ(INSTR_MEM_READ),
        .INSTR_MEM_BUSYWAIT(INSTR_MEM_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
        .REDIRECT(REDIRECT), .REDIRECT_TARGET(REDIRECT_TARGET), .ID_HOLD(ID_HOLD),
        .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_INSTRUCTION(ID_INSTRUCTION),
        .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    // Memory model: each access is busy for mem_wait cycles, then answers addr
    assign INSTR_MEM_BUSYWAIT = INSTR_MEM_READ && (mem_force_busy || (mem_cnt < mem_wait));
    assign INSTRUCTION        = INSTR_MEM_ADDR;

    always @(posedge CLK or posedge RESET) begin
        if (RESET)                                         mem_cnt <= 0;
        else if (INSTR_MEM_READ && !INSTR_MEM_BUSYWAIT)    mem_cnt <= 0;
        else if (INSTR_MEM_READ)                           mem_cnt <= mem_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, req);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic hold);
        RESET    = 1'b1;
        REDIRECT = 1'b0;
        ID_HOLD  = hold;
        mem_force_busy = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    initial begin
        // Reset state and zero-wait streaming
        step();
        step();
        check("rst_valid", 32'(ID_VALID), 32'd0);
        check("rst_level", 32'(FIFO_LEVEL), 32'd0);
        check("rst_pc", ID_PC, 32'd0);
        check("rst_instr", ID_INSTRUCTION, 32'd0);
        check("rst_addr", INSTR_MEM_ADDR, 32'd0);
        RESET = 1'b0;
        check("rel_read", 32'(INSTR_MEM_READ), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", 32'(ID_VALID), 32'd1);
            check("stream_pc", ID_PC, 32'(i * 4));
            check("stream_instr", ID_INSTRUCTION, 32'(i * 4));
            check("stream_read", 32'(INSTR_MEM_READ), 32'd1);
        end

        // ID hold fills the FIFO, then release drains in order
        do_reset(1'b1);
        repeat (8) step();
        check("hold_level", 32'(FIFO_LEVEL), 32'd4);
        check("hold_read", 32'(INSTR_MEM_READ), 32'd0);
        check("hold_addr", INSTR_MEM_ADDR, 32'h10);
        ID_HOLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(ID_VALID), 32'd1);
            check("drain_pc", ID_PC, 32'(i * 4));
            step();
        end

        // Three busy cycles per access
        mem_wait = 3;
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                check("busy_addr", INSTR_MEM_ADDR, 32'(k * 4));
                check("busy_bw", 32'(INSTR_MEM_BUSYWAIT), (c < 3) ? 32'd1 : 32'd0);
                if (c > 0) check("busy_novalid", 32'(ID_VALID), 32'd0);
                step();
            end
            check("busy_valid", 32'(ID_VALID), 32'd1);
            check("busy_pc", ID_PC, 32'(k * 4));
        end
        mem_wait = 0;

        // Zero-wait redirect with 3 entries buffered (ID_HOLD also high)
        do_reset(1'b1);
        repeat (3) step();
        check("rd_pre_level", 32'(FIFO_LEVEL), 32'd3);
        REDIRECT = 1'b1;
        REDIRECT_TARGET = 32'h100;
        step();
        REDIRECT = 1'b0;
        ID_HOLD  = 1'b0;
        check("rd_level", 32'(FIFO_LEVEL), 32'd0);
        check("rd_valid0", 32'(ID_VALID), 32'd0);
        check("rd_addr", INSTR_MEM_ADDR, 32'h100);
        step();
        check("rd_valid1", 32'(ID_VALID), 32'd1);
        check("rd_pc0", ID_PC, 32'h100);
        step();
        check("rd_pc1", ID_PC, 32'h104);
        check("rd_instr1", ID_INSTRUCTION, 32'h104);

        // Redirect while the access to 0x20 is stalled
        do_reset(1'b0);
        repeat (8) step();
        check("dr_pre_addr", INSTR_MEM_ADDR, 32'h20);
        mem_force_busy = 1'b1;
        REDIRECT = 1'b1;
        REDIRECT_TARGET = 32'h200;
        step();
        REDIRECT = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("dr_read", 32'(INSTR_MEM_READ), 32'd1);
            check("dr_addr", INSTR_MEM_ADDR, 32'h20);
            check("dr_valid", 32'(ID_VALID), 32'd0);
            step();
        end
        mem_force_busy = 1'b0;
        check("dr_last_addr", INSTR_MEM_ADDR, 32'h20);
        step();
        check("dr_novalid", 32'(ID_VALID), 32'd0);
        check("dr_new_addr", INSTR_MEM_ADDR, 32'h200);
        step();
        check("dr_valid1", 32'(ID_VALID), 32'd1);
        check("dr_pc", ID_PC, 32'h200);

        // Asynchronous reset in the middle of a stalled access
        do_reset(1'b1);
        step();
        step();
        mem_force_busy = 1'b1;
        #1;
        check("ar_pre_level", 32'(FIFO_LEVEL), 32'd2);
        check("ar_pre_bw", 32'(INSTR_MEM_BUSYWAIT), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        check("ar_valid", 32'(ID_VALID), 32'd0);
        check("ar_level", 32'(FIFO_LEVEL), 32'd0);
        check("ar_pc", ID_PC, 32'd0);
        check("ar_addr", INSTR_MEM_ADDR, 32'd0);
        step();
        RESET = 1'b0;
        mem_force_busy = 1'b0;
        check("ar_read", 32'(INSTR_MEM_READ), 32'd1);
        step();
        check("ar_valid1", 32'(ID_VALID), 32'd1);
        check("ar_pc1", ID_PC, 32'd0);
        step();
        check("ar_pc_next", INSTR_MEM_ADDR, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
